// File: rtl/sid_pkg.sv
// Shared constants and types for the SID audio output path.
package sid_pkg;

  localparam int unsigned SID_SAMPLE_BITS   = 16;
  localparam int unsigned SID_I2S_SLOTS     = 32;
  localparam int unsigned SID_I2S_SLOT_BITS = $clog2(SID_I2S_SLOTS);
  localparam int unsigned SID_I2S_FRAME_BITS = 2 * SID_SAMPLE_BITS;

  localparam int unsigned SID_CLK_DIV_MIN  = 1;
  localparam int unsigned SID_CLK_DIV_MAX  = 255;
  localparam int unsigned SID_CLK_DIV_BITS = 8;

  // Source of the sample loaded at the start of a frame
  typedef enum logic [1:0] {
    SRC_NEW  = 2'd0,
    SRC_HOLD = 2'd1,
    SRC_LAST = 2'd2
  } frame_src_e;

  typedef struct packed {
    logic                       full;
    logic [SID_SAMPLE_BITS-1:0] data;
  } hold_t;

  function automatic logic clk_div_legal(input int unsigned div);
    return (div >= SID_CLK_DIV_MIN) && (div <= SID_CLK_DIV_MAX);
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// BCLK generator: divider wraps every CLK_DIV cycles and toggles BCLK.
// fall_c / rise_c are single-cycle strobes on the edge where BCLK toggles.
module sid_i2s_clkgen
  import sid_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk,
  output logic fall_c,
  output logic rise_c
);

  localparam logic [SID_CLK_DIV_BITS-1:0] DIV_TERM = SID_CLK_DIV_BITS'(CLK_DIV - 1);

  logic [SID_CLK_DIV_BITS-1:0] div;
  logic                        terminal_c;

  assign terminal_c = (div == DIV_TERM);
  assign fall_c     = terminal_c & bclk;
  assign rise_c     = terminal_c & ~bclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div  <= '0;
      bclk <= 1'b0;
    end else if (terminal_c) begin
      div  <= '0;
      bclk <= ~bclk;
    end else begin
      div  <= div + SID_CLK_DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// SID mono sample to I2S DAC transmitter (sample duplicated on both channels).
// Define SID_I2S_LEFT_JUSTIFIED_EN for left-justified output; default is Philips I2S.
module sid_i2s_tx
  import sid_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SID_SAMPLE_BITS-1:0] sample,
  input  logic                       sample_valid,
  output logic                       bclk,
  output logic                       lrclk,
  output logic                       sdata,
  output logic                       underrun,
  output logic                       overrun
);

  localparam logic [SID_I2S_SLOT_BITS-1:0] SLOT_LAST  = SID_I2S_SLOT_BITS'(SID_I2S_SLOTS - 1);
  localparam logic [SID_I2S_SLOT_BITS-1:0] SLOT_RIGHT = SID_I2S_SLOT_BITS'(SID_I2S_SLOTS / 2);

  logic fall_c;
  logic rise_c;
  logic unused_rise;

  sid_i2s_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .bclk   (bclk),
    .fall_c (fall_c),
    .rise_c (rise_c)
  );

  // Data is launched on falls only; rise is kept for future DAC-side use.
  assign unused_rise = rise_c;

  logic [SID_I2S_SLOT_BITS-1:0]  slot, slot_d;
  logic [SID_I2S_FRAME_BITS-1:0] shift, shift_d;
  hold_t                         hold, hold_d;
  logic [SID_SAMPLE_BITS-1:0]    last, last_d;
  logic                          lrclk_d, sdata_d, underrun_d, overrun_d;
  logic                          load_c;
  frame_src_e                    src_c;
  logic [SID_SAMPLE_BITS-1:0]    word_c;

  assign load_c = fall_c && (slot == SLOT_LAST);

  // Frame source selection: fresh strobe beats held sample beats repeat.
  always_comb begin
    src_c  = SRC_LAST;
    word_c = last;
    if (sample_valid) begin
      src_c  = SRC_NEW;
      word_c = sample;
    end else if (hold.full) begin
      src_c  = SRC_HOLD;
      word_c = hold.data;
    end
  end

  // Next-state for hold register, slot counter, shifter and serial outputs
  always_comb begin
    slot_d     = slot;
    shift_d    = shift;
    hold_d     = hold;
    last_d     = last;
    lrclk_d    = lrclk;
    sdata_d    = sdata;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;

    if (load_c) begin
      last_d = word_c;
      case (src_c)
        SRC_NEW: begin
          overrun_d   = hold.full;
          hold_d.full = 1'b0;
        end
        SRC_HOLD: begin
          hold_d.full = 1'b0;
        end
        default: begin
          underrun_d = 1'b1;
        end
      endcase
    end else if (sample_valid) begin
      overrun_d   = hold.full;
      hold_d.full = 1'b1;
      hold_d.data = sample;
    end

    if (fall_c) begin
      slot_d  = slot + SID_I2S_SLOT_BITS'(1);
      shift_d = load_c ? {word_c, word_c} : {shift[SID_I2S_FRAME_BITS-2:0], 1'b0};
      lrclk_d = (slot_d >= SLOT_RIGHT);
`ifdef SID_I2S_LEFT_JUSTIFIED_EN
      sdata_d = shift_d[SID_I2S_FRAME_BITS-1];
`else
      // One-slot delay: emit the bit that was current during the slot just ended.
      sdata_d = shift[SID_I2S_FRAME_BITS-1];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= SLOT_LAST;
      shift    <= '0;
      hold     <= '0;
      last     <= '0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      slot     <= slot_d;
      shift    <= shift_d;
      hold     <= hold_d;
      last     <= last_d;
      lrclk    <= lrclk_d;
      sdata    <= sdata_d;
      underrun <= underrun_d;
      overrun  <= overrun_d;
    end
  end

endmodule
